regfile_wb_arbiter: RTL and testbench
=====================================

# regfile_wb_arbiter

Write-back arbiter feeding the single register-file write port (`enrd`/`rdsel`/`rd`). It merges single-cycle ALU results with multi-cycle load results: ALU writes have fixed priority, and load results wait in a small FIFO. Outputs are registered, so every register-file write is presented one clock after arbitration. An optional scoreboard reports read-after-write hazards on the decode-stage read selects.

## Interface
- `DEPTH`, 2: load-result FIFO entries (power of two, ≥2)
- `clk` in 1: clock, rising edge
- `rst` in 1: synchronous reset, active-high
- `alu_valid` in 1: ALU result present this cycle; always accepted, no backpressure
- `alu_rdsel` in 5: ALU destination register
- `alu_data` in 32: ALU result
- `ld_valid` in 1: load result offered
- `ld_ready` out 1: load result accepted when `ld_valid && ld_ready`
- `ld_rdsel` in 5: load destination register
- `ld_data` in 32: load data
- `enrd` out 1: register-file write enable (registered)
- `rdsel` out 5: register-file write select (registered)
- `rd` out 32: register-file write data (registered)
- `rs1sel`, `rs2sel` in 5: decode read selects (scoreboard only)
- `stall` out 1: RAW hazard on `rs1sel`/`rs2sel` (scoreboard only)

## Operation
- Reset: `enrd`=0, `rdsel`=0, `rd`=0, FIFO empty, `stall`=0, `ld_ready`=0 while `rst`=1.
- `ld_ready` = !full. It is purely state-based and has no combinational path from `alu_valid` or `ld_valid`.
- Each cycle, one write is selected, in this priority order:
  1. ALU, if `alu_valid`.
  2. FIFO head, if the FIFO is non-empty.
  3. Incoming load, if the FIFO is empty and the load handshake completes. This is a bypass: the load is not enqueued.
- An accepted load that does not win arbitration is pushed to the FIFO tail.
- The FIFO supports a simultaneous push and pop.
- Destination register 0 is never written. An ALU or load result with destination 0 occupies no slot, is not enqueued, and produces `enrd`=0.
- WAW cancel: an `alu_valid` write to register R kills every valid FIFO entry targeting R, and also kills an incoming load to R in the same cycle.
  - A killed entry still drains in order but produces `enrd`=0.
  - This applies only when R≠0.
- The FIFO keeps arrival order. Killed entries consume their pop slot.

## Timing
- ALU result at edge N is written (`enrd`=1) in the cycle after edge N, and the register file commits it at edge N+1.
- Load latency:
  - 1 cycle when bypassed.
  - Otherwise 1 + (ALU-busy cycles) + (entries ahead of it).
- Sustained ALU traffic starves the FIFO. This is intentional: the core guarantees gaps.
- If a load is offered while `ld_ready`=0, it is held by the producer. Inputs must stay stable until accepted.
- If `rst` is asserted mid-drain, all queued and in-flight writes are discarded, and `enrd`=0 on the next cycle.

## Configuration
- `WB_SCOREBOARD_EN` defined:
  - `stall` = (`rs1sel`≠0 or `rs2sel`≠0) matching the destination of any valid, unkilled FIFO entry.
  - Also asserted when `enrd`=1 and `rdsel` matches, because the register file read is stale until the commit edge.
  - `stall` is combinational from the selects and state.
- Macro undefined: `rs1sel`, `rs2sel` and `stall` are absent. The core must guarantee hazard freedom externally.

## Structure
- Shared package `riscv_pkg`:
  - `REG_W`=32 and `SEL_W`=5.
  - A `wb_entry_t` struct with fields valid, kill, sel, data.
- One sub-module, `wb_fifo`, a parameterized synchronous FIFO with full/empty flags and an in-place kill-by-select port.
- The arbiter, the output register and the scoreboard compare live in the top module.

## Test plan
- Load alone: reset, then `ld_valid` with R5=0x1234 → next cycle `enrd`=1, `rdsel`=5, `rd`=0x1234 (bypass).
- Collision: ALU R3=0xA and load R4=0xB in the same cycle → `enrd` writes R3 in cycle +1, then R4 in cycle +2.
- Full FIFO: `alu_valid` held for 4 cycles while loads R1, R2, R6 are offered → `ld_ready`=0 after 2 entries; the third load is held. After the ALU stops, writes drain in order R1, R2, R6.
- WAW: load R7=0x1 queued behind ALU traffic, then ALU R7=0x2 → R7 is written once with 0x2; the killed slot shows `enrd`=0.
- x0: ALU and load results to R0 → `enrd` stays 0 and the FIFO stays empty.
- With `WB_SCOREBOARD_EN`: queued load R9 and `rs2sel`=9 → `stall`=1; `stall` is 0 on the cycle after the R9 write commits.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared register-file write-back types: register/select widths and the queued write-back entry.
// Entries carry their own valid and kill flags so a queue can cancel writes in place.
package riscv_pkg;

    localparam int REG_W = 32;
    localparam int SEL_W = 5;

    typedef struct packed {
        logic             valid;
        logic             kill;
        logic [SEL_W-1:0] sel;
        logic [REG_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Purpose: in-order write-back entry queue with an in-place kill-by-select port.
// Latency: a pushed entry is visible at head_dat one clock after the push edge.
// Backpressure: full is raised at DEPTH entries; the caller must not push while full.
module wb_fifo
    import riscv_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push_vld,
    input  wb_entry_t               push_dat,
    input  logic                    pop_vld,
    input  logic                    kill_vld,
    input  logic [SEL_W-1:0]        kill_sel,
    output wb_entry_t               head_dat,
    output wb_entry_t [DEPTH-1:0]   slots,
    output logic                    full,
    output logic                    empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);

    wb_entry_t [DEPTH-1:0] mem;
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [AW:0]           count;

    assign head_dat = mem[rd_ptr];
    assign slots    = mem;
    assign full     = (count == CNT_FULL);
    assign empty    = (count == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            mem    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // Killed entries stay queued so arrival order and pop slots are preserved.
            if (kill_vld) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (mem[i].valid && (mem[i].sel == kill_sel)) begin
                        mem[i].kill <= 1'b1;
                    end
                end
            end
            if (pop_vld) begin
                mem[rd_ptr].valid <= 1'b0;
                rd_ptr            <= rd_ptr + PTR_ONE;
            end
            if (push_vld) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= wr_ptr + PTR_ONE;
            end
            case ({push_vld, pop_vld})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Purpose: merges ALU and load results onto the single register-file write port; optional RAW scoreboard under WB_SCOREBOARD_EN.
// Latency: 1 clock for ALU and bypassed loads; queued loads wait for ALU-free cycles and older entries.
// Backpressure: ALU never stalls; ld_ready = !full, so loads are held by the producer while the queue is full.
module regfile_wb_arbiter
    import riscv_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             alu_valid,
    input  logic [SEL_W-1:0] alu_rdsel,
    input  logic [REG_W-1:0] alu_data,
    input  logic             ld_valid,
    output logic             ld_ready,
    input  logic [SEL_W-1:0] ld_rdsel,
    input  logic [REG_W-1:0] ld_data,
`ifdef WB_SCOREBOARD_EN
    input  logic [SEL_W-1:0] rs1sel,
    input  logic [SEL_W-1:0] rs2sel,
    output logic             stall,
`endif
    output logic             enrd,
    output logic [SEL_W-1:0] rdsel,
    output logic [REG_W-1:0] rd
);

    wb_entry_t             fifo_head;
    wb_entry_t             fifo_push_dat;
    wb_entry_t [DEPTH-1:0] fifo_slots;
    logic                  fifo_full;
    logic                  fifo_empty;

    logic alu_live;
    logic ld_live;
    logic pop_vld;
    logic bypass;
    logic push_vld;

    // Writes to x0 never need the port, so they neither win arbitration nor enqueue.
    assign ld_ready = !rst && !fifo_full;
    assign alu_live = alu_valid && (alu_rdsel != '0);
    assign ld_live  = ld_valid && ld_ready && (ld_rdsel != '0);
    assign pop_vld  = !alu_live && !fifo_empty;
    assign bypass   = !alu_live && fifo_empty && ld_live;
    assign push_vld = ld_live && !bypass;

    always_comb begin
        fifo_push_dat       = '0;
        fifo_push_dat.valid = 1'b1;
        fifo_push_dat.kill  = alu_live && (alu_rdsel == ld_rdsel);
        fifo_push_dat.sel   = ld_rdsel;
        fifo_push_dat.data  = ld_data;
    end

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push_vld (push_vld),
        .push_dat (fifo_push_dat),
        .pop_vld  (pop_vld),
        .kill_vld (alu_live),
        .kill_sel (alu_rdsel),
        .head_dat (fifo_head),
        .slots    (fifo_slots),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            enrd  <= 1'b0;
            rdsel <= '0;
            rd    <= '0;
        end else if (alu_live) begin
            enrd  <= 1'b1;
            rdsel <= alu_rdsel;
            rd    <= alu_data;
        end else if (pop_vld) begin
            enrd  <= !fifo_head.kill;
            rdsel <= fifo_head.sel;
            rd    <= fifo_head.data;
        end else if (bypass) begin
            enrd  <= 1'b1;
            rdsel <= ld_rdsel;
            rd    <= ld_data;
        end else begin
            enrd  <= 1'b0;
        end
    end

`ifdef WB_SCOREBOARD_EN
    logic rs1_hit;
    logic rs2_hit;

    // The write on the port is not readable until its commit edge, so it counts as pending.
    always_comb begin
        rs1_hit = enrd && (rdsel == rs1sel);
        rs2_hit = enrd && (rdsel == rs2sel);
        for (int i = 0; i < DEPTH; i++) begin
            if (fifo_slots[i].valid && !fifo_slots[i].kill) begin
                if (fifo_slots[i].sel == rs1sel) rs1_hit = 1'b1;
                if (fifo_slots[i].sel == rs2sel) rs2_hit = 1'b1;
            end
        end
    end

    assign stall = (rs1_hit && (rs1sel != '0)) || (rs2_hit && (rs2sel != '0));
`else
    logic fifo_slots_unused;
    assign fifo_slots_unused = ^fifo_slots;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: bypass, collision, full queue, WAW kill, x0, reset mid-drain, scoreboard.
module tb_regfile_wb_arbiter;

    logic        clk;
    logic        rst;
    logic        alu_valid;
    logic [4:0]  alu_rdsel;
    logic [31:0] alu_data;
    logic        ld_valid;
    logic        ld_ready;
    logic [4:0]  ld_rdsel;
    logic [31:0] ld_data;
    logic        enrd;
    logic [4:0]  rdsel;
    logic [31:0] rd;
`ifdef WB_SCOREBOARD_EN
    logic [4:0]  rs1sel;
    logic [4:0]  rs2sel;
    logic        stall;
`endif

    int n_cmp;
    int n_err;

    regfile_wb_arbiter #(
        .DEPTH (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .alu_valid (alu_valid),
        .alu_rdsel (alu_rdsel),
        .alu_data  (alu_data),
        .ld_valid  (ld_valid),
        .ld_ready  (ld_ready),
        .ld_rdsel  (ld_rdsel),
        .ld_data   (ld_data),
`ifdef WB_SCOREBOARD_EN
        .rs1sel    (rs1sel),
        .rs2sel    (rs2sel),
        .stall     (stall),
`endif
        .enrd      (enrd),
        .rdsel     (rdsel),
        .rd        (rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_wr(input string tag, input logic [4:0] sel, input logic [31:0] data);
        chk({tag, ".enrd"}, {31'd0, enrd}, 32'd1);
        chk({tag, ".rdsel"}, {27'd0, rdsel}, {27'd0, sel});
        chk({tag, ".rd"}, rd, data);
    endtask

    task automatic drive_alu(input logic v, input logic [4:0] sel, input logic [31:0] data);
        alu_valid = v;
        alu_rdsel = sel;
        alu_data  = data;
    endtask

    task automatic drive_ld(input logic v, input logic [4:0] sel, input logic [31:0] data);
        ld_valid = v;
        ld_rdsel = sel;
        ld_data  = data;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst   = 1'b1;
        drive_alu(1'b0, 5'd0, 32'h0);
        drive_ld(1'b0, 5'd0, 32'h0);
`ifdef WB_SCOREBOARD_EN
        rs1sel = 5'd0;
        rs2sel = 5'd0;
`endif
        tick();
        tick();

        // Reset state
        chk("rst.enrd", {31'd0, enrd}, 32'd0);
        chk("rst.rdsel", {27'd0, rdsel}, 32'd0);
        chk("rst.rd", rd, 32'd0);
        chk("rst.ld_ready", {31'd0, ld_ready}, 32'd0);
`ifdef WB_SCOREBOARD_EN
        chk("rst.stall", {31'd0, stall}, 32'd0);
`endif
        rst = 1'b0;
        #1;
        chk("post_rst.ld_ready", {31'd0, ld_ready}, 32'd1);

        // Load alone bypasses in one cycle
        drive_ld(1'b1, 5'd5, 32'h1234);
        tick();
        drive_ld(1'b0, 5'd0, 32'h0);
        chk_wr("bypass", 5'd5, 32'h1234);
        tick();
        chk("bypass.idle", {31'd0, enrd}, 32'd0);

        // ALU and load collide: ALU first, load next cycle
        drive_alu(1'b1, 5'd3, 32'hA);
        drive_ld(1'b1, 5'd4, 32'hB);
        tick();
        drive_alu(1'b0, 5'd0, 32'h0);
        drive_ld(1'b0, 5'd0, 32'h0);
        chk_wr("coll.alu", 5'd3, 32'hA);
        tick();
        chk_wr("coll.ld", 5'd4, 32'hB);
        tick();
        chk("coll.idle", {31'd0, enrd}, 32'd0);

        // Four ALU cycles fill the queue; third load is held until space frees
        drive_alu(1'b1, 5'd10, 32'h100);
        drive_ld(1'b1, 5'd1, 32'h11);
        tick();
        chk_wr("full.alu10", 5'd10, 32'h100);
        chk("full.rdy1", {31'd0, ld_ready}, 32'd1);
        drive_alu(1'b1, 5'd11, 32'h101);
        drive_ld(1'b1, 5'd2, 32'h22);
        tick();
        chk_wr("full.alu11", 5'd11, 32'h101);
        chk("full.rdy2", {31'd0, ld_ready}, 32'd0);
        drive_alu(1'b1, 5'd12, 32'h102);
        drive_ld(1'b1, 5'd6, 32'h66);
        tick();
        chk_wr("full.alu12", 5'd12, 32'h102);
        chk("full.rdy3", {31'd0, ld_ready}, 32'd0);
        drive_alu(1'b1, 5'd13, 32'h103);
        tick();
        chk_wr("full.alu13", 5'd13, 32'h103);
        chk("full.rdy4", {31'd0, ld_ready}, 32'd0);
        drive_alu(1'b0, 5'd0, 32'h0);
        tick();
        chk_wr("full.r1", 5'd1, 32'h11);
        chk("full.rdy5", {31'd0, ld_ready}, 32'd1);
        tick();
        drive_ld(1'b0, 5'd0, 32'h0);
        chk_wr("full.r2", 5'd2, 32'h22);
        tick();
        chk_wr("full.r6", 5'd6, 32'h66);
        tick();
        chk("full.idle", {31'd0, enrd}, 32'd0);

        // WAW: a queued load to R7 is killed by a younger ALU write to R7
        drive_alu(1'b1, 5'd8, 32'h8);
        drive_ld(1'b1, 5'd7, 32'h1);
        tick();
        chk_wr("waw.alu8", 5'd8, 32'h8);
        drive_ld(1'b0, 5'd0, 32'h0);
        drive_alu(1'b1, 5'd7, 32'h2);
        tick();
        chk_wr("waw.alu7", 5'd7, 32'h2);
        drive_alu(1'b0, 5'd0, 32'h0);
        tick();
        chk("waw.killed", {31'd0, enrd}, 32'd0);
        tick();
        chk("waw.idle", {31'd0, enrd}, 32'd0);
        chk("waw.rdy", {31'd0, ld_ready}, 32'd1);

        // WAW on a load arriving in the same cycle as the ALU write
        drive_alu(1'b1, 5'd12, 32'h3);
        drive_ld(1'b1, 5'd12, 32'h4);
        tick();
        drive_alu(1'b0, 5'd0, 32'h0);
        drive_ld(1'b0, 5'd0, 32'h0);
        chk_wr("waw_same.alu", 5'd12, 32'h3);
        tick();
        chk("waw_same.killed", {31'd0, enrd}, 32'd0);
        tick();
        chk("waw_same.idle", {31'd0, enrd}, 32'd0);

        // x0 results never write and never occupy the queue
        drive_alu(1'b1, 5'd0, 32'hDEAD);
        drive_ld(1'b1, 5'd0, 32'hBEEF);
        tick();
        chk("x0.enrd", {31'd0, enrd}, 32'd0);
        chk("x0.rdy1", {31'd0, ld_ready}, 32'd1);
        drive_alu(1'b1, 5'd14, 32'h14);
        tick();
        chk_wr("x0.alu14", 5'd14, 32'h14);
        chk("x0.rdy2", {31'd0, ld_ready}, 32'd1);
        drive_alu(1'b1, 5'd15, 32'h15);
        tick();
        chk_wr("x0.alu15", 5'd15, 32'h15);
        chk("x0.rdy3", {31'd0, ld_ready}, 32'd1);
        drive_alu(1'b0, 5'd0, 32'h0);
        drive_ld(1'b0, 5'd0, 32'h0);
        tick();
        chk("x0.idle", {31'd0, enrd}, 32'd0);

        // Reset with two queued loads discards them
        drive_alu(1'b1, 5'd20, 32'h20);
        drive_ld(1'b1, 5'd21, 32'h21);
        tick();
        drive_alu(1'b1, 5'd22, 32'h22);
        drive_ld(1'b1, 5'd23, 32'h23);
        tick();
        chk("mrst.full", {31'd0, ld_ready}, 32'd0);
        drive_alu(1'b0, 5'd0, 32'h0);
        drive_ld(1'b0, 5'd0, 32'h0);
        rst = 1'b1;
        tick();
        chk("mrst.enrd", {31'd0, enrd}, 32'd0);
        chk("mrst.rdy", {31'd0, ld_ready}, 32'd0);
        rst = 1'b0;
        tick();
        chk("mrst.drain1", {31'd0, enrd}, 32'd0);
        chk("mrst.rdy_after", {31'd0, ld_ready}, 32'd1);
        tick();
        chk("mrst.drain2", {31'd0, enrd}, 32'd0);

`ifdef WB_SCOREBOARD_EN
        // Scoreboard: queued R9 stalls rs2 until its write has committed
        rs2sel = 5'd9;
        #1;
        chk("sb.idle", {31'd0, stall}, 32'd0);
        drive_alu(1'b1, 5'd1, 32'h1);
        drive_ld(1'b1, 5'd9, 32'h99);
        tick();
        drive_alu(1'b0, 5'd0, 32'h0);
        drive_ld(1'b0, 5'd0, 32'h0);
        chk("sb.queued", {31'd0, stall}, 32'd1);
        tick();
        chk_wr("sb.wr9", 5'd9, 32'h99);
        chk("sb.writing", {31'd0, stall}, 32'd1);
        tick();
        chk("sb.committed", {31'd0, stall}, 32'd0);
        rs2sel = 5'd0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
